rtc_ng: RTL and testbench
=========================

Name: rtc_ng

Overview:
Next-generation PTP real-time clock: a 48-bit seconds and 30-bit nanoseconds time-of-day counter, parametrised in field widths and modulo.
- Keeps the full period fraction internally, so no delta-sigma truncation.
- Adds signed multi-cycle slew adjustment with a busy/done handshake, a load-range check and a PPS output.
- Sits between the servo/register block (loads, period, adjustments) and the timestamp units (time outputs).

Parameters:
SEC_W, 48, seconds width
NS_INT_W, 30, integer ns width
NS_FRAC_W, 8, ns fraction bits exported on time_reg_ns
PER_INT_W, 8, period integer ns bits
PER_FRAC_W, 32, period fraction bits; internal accumulator fraction width
NS_MODULO, 1000000000, ns rollover value (integer ns)
PERIOD_RST, 40'h08_00000000, period after reset (8 ns)
PPS_WIDTH, 8, PPS pulse length in clk cycles (1..2^16-1)
ADJ_CNT_W, 32, slew cycle-count width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
time_ld  in  1  direct ToD load strobe
time_ns_in  in  NS_INT_W+NS_FRAC_W  ns.fraction to load
time_sec_in  in  SEC_W  seconds to load
load_err  out  1  1-cycle pulse: load rejected
period_ld  in  1  period load strobe
period_in  in  PER_INT_W+PER_FRAC_W  unsigned nominal period
adj_ld  in  1  slew start strobe
adj_step  in  PER_INT_W+PER_FRAC_W+1  signed two's-complement per-cycle delta
adj_cycles  in  ADJ_CNT_W  slew length in cycles
adj_busy  out  1  slew in progress
adj_done  out  1  1-cycle pulse: slew completed
time_reg_ns  out  NS_INT_W+NS_FRAC_W  ns with fraction
time_reg_sec  out  SEC_W  seconds
time_ptp_ns  out  32  zero-extended integer ns
time_ptp_sec  out  SEC_W  seconds
pps  out  1  pulse-per-second

Behaviour:
- Reset (rst_n low, async):
  - Time = 0; period_fix = PERIOD_RST; inc_q = 0.
  - Slew FSM = IDLE; pps, load_err, adj_busy, adj_done = 0.
- Registers:
  - Period register period_fix.
  - Registered increment inc_q, width PER_INT_W+PER_FRAC_W.
  - Accumulator acc_ns: NS_INT_W integer bits + PER_FRAC_W fraction bits.
  - Seconds counter acc_sec.
- Outputs:
  - time_reg_ns = acc_ns top NS_INT_W+NS_FRAC_W bits, i.e. the fraction truncated to NS_FRAC_W.
  - time_ptp_ns = {zeros, integer ns}.
  - All outputs are registered.
- Increment, recomputed every cycle:
  - sum = period_fix + (state==SLEW ? adj_step : 0), evaluated signed in PER_INT_W+PER_FRAC_W+2 bits.
  - If sum < 0, inc_q <= 0 (clamp; time never runs backward).
  - Overflow above 2^(PER_INT_W+PER_FRAC_W)-1 saturates to all-ones.
- Accumulate, each edge without time_ld:
  - nxt = acc_ns + inc_q.
  - If nxt >= NS_MODULO<<PER_FRAC_W: acc_ns <= nxt - modulo, acc_sec <= acc_sec+1 (wraps at 2^SEC_W).
  - Otherwise acc_ns <= nxt.
  - A single subtract suffices, because inc_q < modulo.
- time_ld has priority over accumulation:
  - Loads ns.fraction with the lower internal fraction bits cleared, and loads sec.
  - If the integer ns >= NS_MODULO: the load is ignored, time keeps accumulating, and load_err pulses the cycle after.
  - Accumulation resumes on the next edge.
- Period latency:
  - period_ld sampled at edge k → period_fix after k → inc_q after k+1.
  - The first new-period advance occurs at edge k+2.
- Slew FSM, states IDLE and SLEW:
  - adj_ld at edge k with adj_cycles=N>0: state=SLEW, cnt=N.
  - In SLEW, cnt decrements each edge. At the edge where cnt==1: state=IDLE, adj_done=1 for one cycle.
  - adj_busy = (state==SLEW). It is high for exactly N cycles.
  - The accumulator gets the step-adjusted increment at edges k+2..k+N+1.
  - adj_cycles=0: no step applied, adj_busy stays 0, adj_done pulses after edge k.
  - adj_ld while in SLEW: restart with the new step and count. No adj_done is produced for the aborted slew.
  - period_ld during SLEW is allowed; the new base applies per the period latency rule.
- PPS:
  - On the edge that increments acc_sec by rollover, pps <= 1 for PPS_WIDTH cycles, via a 16-bit down-counter.
  - A time_ld does not trigger pps.
  - A new rollover while pps is active reloads the counter.
- Reset mid-slew or mid-PPS aborts immediately; no done pulse is produced.

Decomposition:
- Package rtc_ng_pkg holds:
  - Width localparams: NS_W = NS_INT_W+NS_FRAC_W, PER_W = PER_INT_W+PER_FRAC_W.
  - The FSM state enum {IDLE, SLEW}.
  - Default modulo and period constants.
- One sub-module, rtc_ng_slew: slew FSM, counter, increment mux and clamp; outputs inc_q, adj_busy, adj_done.
- Top level holds the accumulator, load check and PPS.

Test Plan:
- Rollover: PERIOD_RST, time_ld ns=999_999_992<<8, sec=5 → next edge ns=0, sec=6, pps high 8 cycles; time_ptp_ns=0.
- Fraction: period_ld 0x08_80000000, time_ld 0 → after the period takes effect, time_reg_ns integer ns advances 8,17,25,34 and fraction alternates 0x80/0x00.
- Slew: period 8 ns, adj_step=-0.5 ns (0x1_FF_80000000), adj_cycles=4 → 4 increments of 7.5 ns (30 ns total); adj_busy high 4 cycles; single adj_done pulse.
- Clamp and zero length:
  - adj_step=-16 ns, N=3 → time frozen 3 cycles, then resumes at 8 ns.
  - adj_cycles=0 → adj_done one cycle, adj_busy never high.
- Load error: time_ld with ns=1_000_000_000<<8 → load_err pulse; time continues from its prior value; no pps.
- Reset mid-slew: rst_n low during SLEW → all outputs 0 immediately, period=8 ns after release, no adj_done.

Source files
------------

// File: rtl/rtc_ng_pkg.sv
// rtc_ng_pkg: shared widths, default constants and slew FSM state type for the rtc_ng clock
package rtc_ng_pkg;
  localparam int DEF_SEC_W = 48;
  localparam int DEF_NS_INT_W = 30;
  localparam int DEF_NS_FRAC_W = 8;
  localparam int DEF_PER_INT_W = 8;
  localparam int DEF_PER_FRAC_W = 32;
  localparam int DEF_ADJ_CNT_W = 32;
  localparam int DEF_PPS_WIDTH = 8;
  localparam int NS_W = DEF_NS_INT_W + DEF_NS_FRAC_W;
  localparam int PER_W = DEF_PER_INT_W + DEF_PER_FRAC_W;
  localparam longint unsigned DEF_NS_MODULO = 64'd1000000000;
  localparam logic [PER_W-1:0] DEF_PERIOD_RST = 40'h08_0000_0000;
  typedef enum logic {IDLE, SLEW} slew_state_e;
endpackage

// File: rtl/rtc_ng_if.sv
// rtc_ng_if: servo-side control bus of the clock
//   master (servo): drives time_ld/time_ns_in/time_sec_in, period_ld/period_in,
//                   adj_ld/adj_step/adj_cycles; observes load_err, adj_busy, adj_done
//   slave  (clock): the reverse
interface rtc_ng_if import rtc_ng_pkg::*; #(
  parameter int SW = DEF_SEC_W,
  parameter int NW = NS_W,
  parameter int PW = PER_W,
  parameter int CW = DEF_ADJ_CNT_W
);
  logic time_ld;
  logic [NW-1:0] time_ns_in;
  logic [SW-1:0] time_sec_in;
  logic load_err;
  logic period_ld;
  logic [PW-1:0] period_in;
  logic adj_ld;
  logic [PW:0] adj_step;
  logic [CW-1:0] adj_cycles;
  logic adj_busy;
  logic adj_done;
  modport master (
    output time_ld, time_ns_in, time_sec_in, period_ld, period_in, adj_ld, adj_step, adj_cycles,
    input load_err, adj_busy, adj_done
  );
  modport slave (
    input time_ld, time_ns_in, time_sec_in, period_ld, period_in, adj_ld, adj_step, adj_cycles,
    output load_err, adj_busy, adj_done
  );
endinterface

// File: rtl/rtc_ng_slew.sv
// rtc_ng_slew: period register, slew FSM and per-cycle increment (clamped/saturated)
//   in : clk, rst_n, period_ld/period_in, adj_ld/adj_step/adj_cycles
//   out: inc_q (registered increment), adj_busy, adj_done
module rtc_ng_slew import rtc_ng_pkg::*; #(
  parameter int PW = PER_W,
  parameter int CW = DEF_ADJ_CNT_W,
  parameter logic [PW-1:0] PERIOD_RST = DEF_PERIOD_RST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic period_ld,
  input  logic [PW-1:0] period_in,
  input  logic adj_ld,
  input  logic [PW:0] adj_step,
  input  logic [CW-1:0] adj_cycles,
  output logic [PW-1:0] inc_q,
  output logic adj_busy,
  output logic adj_done
);
  slew_state_e state;
  logic [PW-1:0] period_fix, inc_nxt;
  logic [PW:0] step_q;
  logic [CW-1:0] cnt;
  logic [PW+1:0] sum;
  // Two guard bits: top bit flags a negative sum (clamp), next flags overflow (saturate)
  always_comb begin
    sum = {2'b00, period_fix} + (state == SLEW ? {step_q[PW], step_q} : '0);
    inc_nxt = sum[PW+1] ? '0 : sum[PW] ? '1 : sum[PW-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      period_fix <= PERIOD_RST;
      inc_q <= '0;
      step_q <= '0;
      cnt <= '0;
      adj_busy <= 1'b0;
      adj_done <= 1'b0;
    end else begin
      if (period_ld) period_fix <= period_in;
      inc_q <= inc_nxt;
      adj_done <= 1'b0;
      if (adj_ld) begin
        step_q <= adj_step;
        cnt <= adj_cycles;
        state <= adj_cycles != '0 ? SLEW : IDLE;
        adj_busy <= adj_cycles != '0;
        adj_done <= adj_cycles == '0;
      end else if (state == SLEW) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= IDLE;
          adj_busy <= 1'b0;
          adj_done <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/rtc_ng.sv
// rtc_ng: PTP time-of-day clock (seconds + fractional ns) with slew, load check and PPS
//   in : clk, rst_n, bus (rtc_ng_if.slave: loads, period, slew handshake)
//   out: time_reg_ns/time_reg_sec, time_ptp_ns/time_ptp_sec, pps
module rtc_ng import rtc_ng_pkg::*; #(
  parameter int SEC_W = DEF_SEC_W,
  parameter int NS_INT_W = DEF_NS_INT_W,
  parameter int NS_FRAC_W = DEF_NS_FRAC_W,
  parameter int PER_INT_W = DEF_PER_INT_W,
  parameter int PER_FRAC_W = DEF_PER_FRAC_W,
  parameter longint unsigned NS_MODULO = DEF_NS_MODULO,
  parameter logic [PER_INT_W+PER_FRAC_W-1:0] PERIOD_RST = DEF_PERIOD_RST,
  parameter int unsigned PPS_WIDTH = DEF_PPS_WIDTH,
  parameter int ADJ_CNT_W = DEF_ADJ_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  rtc_ng_if.slave bus,
  output logic [NS_INT_W+NS_FRAC_W-1:0] time_reg_ns,
  output logic [SEC_W-1:0] time_reg_sec,
  output logic [31:0] time_ptp_ns,
  output logic [SEC_W-1:0] time_ptp_sec,
  output logic pps
);
  localparam int NW = NS_INT_W + NS_FRAC_W;
  localparam int PW = PER_INT_W + PER_FRAC_W;
  localparam int AW = NS_INT_W + PER_FRAC_W;
  localparam int AW1 = AW + 1;
  localparam logic [NS_INT_W-1:0] MOD_NS = NS_INT_W'(NS_MODULO);
  localparam logic [AW:0] MOD_ACC = AW1'(NS_MODULO) << PER_FRAC_W;
  logic [AW-1:0] acc_ns;
  logic [SEC_W-1:0] acc_sec;
  logic [PW-1:0] inc_q;
  logic [15:0] pps_cnt;
  logic [AW:0] nxt;
  logic ld_bad, ld_ok, roll;
  rtc_ng_slew #(.PW(PW), .CW(ADJ_CNT_W), .PERIOD_RST(PERIOD_RST)) u_slew (
    .clk(clk),
    .rst_n(rst_n),
    .period_ld(bus.period_ld),
    .period_in(bus.period_in),
    .adj_ld(bus.adj_ld),
    .adj_step(bus.adj_step),
    .adj_cycles(bus.adj_cycles),
    .inc_q(inc_q),
    .adj_busy(bus.adj_busy),
    .adj_done(bus.adj_done)
  );
  // inc_q is always below the modulo, so one conditional subtract normalises nxt
  always_comb begin
    nxt = {1'b0, acc_ns} + AW1'(inc_q);
    ld_bad = bus.time_ns_in[NW-1:NS_FRAC_W] >= MOD_NS;
    ld_ok = bus.time_ld && !ld_bad;
    roll = !ld_ok && nxt >= MOD_ACC;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_ns <= '0;
      acc_sec <= '0;
      pps_cnt <= '0;
      pps <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      bus.load_err <= bus.time_ld && ld_bad;
      acc_ns <= ld_ok ? {bus.time_ns_in, {(PER_FRAC_W-NS_FRAC_W){1'b0}}} : AW'(roll ? nxt - MOD_ACC : nxt);
      acc_sec <= ld_ok ? bus.time_sec_in : acc_sec + SEC_W'(roll);
      pps_cnt <= roll ? 16'(PPS_WIDTH) : pps_cnt - 16'(pps_cnt != '0);
      pps <= roll || pps_cnt > 16'd1;
    end
  assign time_reg_ns = acc_ns[AW-1 -: NW];
  assign time_reg_sec = acc_sec;
  assign time_ptp_ns = 32'(acc_ns[AW-1 -: NS_INT_W]);
  assign time_ptp_sec = acc_sec;
endmodule

// File: tb/tb_rtc_ng.sv
// tb_rtc_ng: directed self-checking bench for rtc_ng
module tb_rtc_ng;
  import rtc_ng_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  rtc_ng_if bus ();
  logic [NS_W-1:0] time_reg_ns;
  logic [DEF_SEC_W-1:0] time_reg_sec, time_ptp_sec;
  logic [31:0] time_ptp_ns;
  logic pps;
  int checks = 0;
  int failures = 0;
  int hi;
  localparam logic [PER_W:0] STEP_HALF = 41'h1_FF_8000_0000;
  localparam logic [PER_W:0] STEP_M16 = 41'h1_F0_0000_0000;
  localparam int FR [4] = '{'h880, 'h1100, 'h1980, 'h2200};
  localparam int SL_NS [7] = '{0, 'h800, 'hF80, 'h1700, 'h1E80, 'h2600, 'h2E00};
  localparam logic SL_B [7] = '{1, 1, 1, 1, 0, 0, 0};
  localparam logic SL_D [7] = '{0, 0, 0, 0, 1, 0, 0};
  localparam int CL_NS [6] = '{0, 'h800, 'h800, 'h800, 'h800, 'h1000};
  localparam logic CL_B [6] = '{1, 1, 1, 0, 0, 0};
  localparam logic CL_D [6] = '{0, 0, 0, 1, 0, 0};
  localparam int Z_NS [3] = '{0, 'h800, 'h1000};
  localparam logic Z_D [3] = '{1, 0, 0};
  rtc_ng dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .time_reg_ns(time_reg_ns),
    .time_reg_sec(time_reg_sec),
    .time_ptp_ns(time_ptp_ns),
    .time_ptp_sec(time_ptp_sec),
    .pps(pps)
  );
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic st(input string tag, input longint ns, input logic b, input logic d);
    chk({tag, "_ns"}, 64'(time_reg_ns), 64'(ns));
    chk({tag, "_busy"}, 64'(bus.adj_busy), 64'(b));
    chk({tag, "_done"}, 64'(bus.adj_done), 64'(d));
  endtask
  function automatic longint nsv(input longint n);
    return n << 8;
  endfunction
  task automatic ld_time(input longint ns, input longint sec);
    bus.time_ld = 1'b1;
    bus.time_ns_in = NS_W'(ns << 8);
    bus.time_sec_in = DEF_SEC_W'(sec);
  endtask
  task automatic slew(input logic [PER_W:0] step, input int n);
    bus.adj_ld = 1'b1;
    bus.adj_step = step;
    bus.adj_cycles = 32'(n);
  endtask
  task automatic clr();
    bus.time_ld = 1'b0;
    bus.period_ld = 1'b0;
    bus.adj_ld = 1'b0;
  endtask
  initial begin
    clr();
    bus.time_ns_in = '0;
    bus.time_sec_in = '0;
    bus.period_in = '0;
    bus.adj_step = '0;
    bus.adj_cycles = '0;
    #1 rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_ns", 64'(time_reg_ns), 0);
    chk("rst_sec", 64'(time_reg_sec), 0);
    chk("rst_flags", 64'({pps, bus.adj_busy, bus.adj_done, bus.load_err}), 0);
    rst_n = 1'b1;
    repeat (3) cyc();
    // rollover from 999_999_992 ns with the 8 ns reset period
    ld_time(999_999_992, 5);
    cyc();
    clr();
    chk("roll_pre_ns", 64'(time_reg_ns), 64'(nsv(999_999_992)));
    chk("roll_pre_sec", 64'(time_reg_sec), 5);
    chk("roll_pre_pps", 64'(pps), 0);
    cyc();
    chk("roll_ns", 64'(time_reg_ns), 0);
    chk("roll_ptp_ns", 64'(time_ptp_ns), 0);
    chk("roll_sec", 64'(time_reg_sec), 6);
    chk("roll_ptp_sec", 64'(time_ptp_sec), 6);
    chk("roll_pps", 64'(pps), 1);
    hi = 1;
    for (int i = 0; i < 11; i++) begin
      cyc();
      hi += int'(pps);
    end
    chk("pps_width", 64'(hi), 8);
    chk("pps_end", 64'(pps), 0);
    // 8.5 ns period, time loaded once the new increment is live
    bus.period_ld = 1'b1;
    bus.period_in = 40'h08_8000_0000;
    cyc();
    clr();
    cyc();
    ld_time(0, 0);
    cyc();
    clr();
    chk("frac_ld", 64'(time_reg_ns), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("frac", 64'(time_reg_ns), 64'(FR[i]));
    end
    bus.period_ld = 1'b1;
    bus.period_in = 40'h08_0000_0000;
    cyc();
    clr();
    cyc();
    // slew of -0.5 ns for 4 cycles
    ld_time(0, 0);
    slew(STEP_HALF, 4);
    cyc();
    clr();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) cyc();
      st("slew", SL_NS[i], SL_B[i], SL_D[i]);
    end
    // -16 ns step clamps the increment to zero for 3 cycles
    ld_time(0, 0);
    slew(STEP_M16, 3);
    cyc();
    clr();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      st("clamp", CL_NS[i], CL_B[i], CL_D[i]);
    end
    // zero-length slew
    ld_time(0, 0);
    slew(STEP_M16, 0);
    cyc();
    clr();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      st("zero", Z_NS[i], 1'b0, Z_D[i]);
    end
    // out-of-range load is rejected
    ld_time(100, 7);
    cyc();
    clr();
    chk("lde_pre_ns", 64'(time_reg_ns), 64'(nsv(100)));
    chk("lde_pre_err", 64'(bus.load_err), 0);
    ld_time(1_000_000_000, 99);
    cyc();
    clr();
    chk("lde_ns", 64'(time_reg_ns), 64'(nsv(108)));
    chk("lde_sec", 64'(time_reg_sec), 7);
    chk("lde_err", 64'(bus.load_err), 1);
    chk("lde_pps", 64'(pps), 0);
    cyc();
    chk("lde_post_ns", 64'(time_reg_ns), 64'(nsv(116)));
    chk("lde_post_err", 64'(bus.load_err), 0);
    // largest legal ns is accepted and rolls over with a remainder
    ld_time(999_999_999, 10);
    cyc();
    clr();
    chk("max_ns", 64'(time_reg_ns), 64'(nsv(999_999_999)));
    chk("max_err", 64'(bus.load_err), 0);
    cyc();
    chk("max_roll_ptp_ns", 64'(time_ptp_ns), 7);
    chk("max_roll_sec", 64'(time_reg_sec), 11);
    chk("max_roll_pps", 64'(pps), 1);
    // reset in the middle of a slew, with a non-default period pending
    bus.period_ld = 1'b1;
    bus.period_in = 40'h08_8000_0000;
    slew(STEP_HALF, 10);
    cyc();
    clr();
    chk("mid_busy", 64'(bus.adj_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ns", 64'(time_reg_ns), 0);
    chk("arst_sec", 64'(time_reg_sec), 0);
    chk("arst_ptp", 64'({time_ptp_ns, 16'(time_ptp_sec)}), 0);
    chk("arst_flags", 64'({pps, bus.adj_busy, bus.adj_done, bus.load_err}), 0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      st("post_rst", Z_NS[i], 1'b0, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
